// File: rtl/img_preproc_stream.sv
// RGB pixel stream to single-channel preprocessor: weighted gray, threshold, inverse or G
// bypass, with frame position tracking and SOL/EOL/SOF/EOF markers on a 3-stage pipeline.
module img_preproc_stream #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 12,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic [DATA_W-1:0] g_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] thresh,
  output logic              dout_valid,
  output logic [DATA_W-1:0] proc_data,
  output logic              dout_sol,
  output logic              dout_eol,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int PROD_W = DATA_W + 8;
  localparam int SUM_W  = DATA_W + 10;

  localparam logic [PROD_W-1:0] K_R      = PROD_W'(COEF_R);
  localparam logic [PROD_W-1:0] K_G      = PROD_W'(COEF_G);
  localparam logic [PROD_W-1:0] K_B      = PROD_W'(COEF_B);
  localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] PIX_ZERO = {DATA_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  // A zero dimension behaves as a single pixel / single line.
  function automatic logic [DIM_W-1:0] norm_dim(input logic [DIM_W-1:0] dim);
    norm_dim = (dim == DIM_ZERO) ? DIM_ONE : dim;
  endfunction

  logic [DIM_W-1:0]  x_cnt_r;
  logic [DIM_W-1:0]  y_cnt_r;
  logic [1:0]        mode_sh_r;
  logic [DATA_W-1:0] thresh_sh_r;
  logic [DIM_W-1:0]  width_sh_r;
  logic [DIM_W-1:0]  height_sh_r;

  logic              at_origin_s;
  logic [1:0]        mode_eff_s;
  logic [DATA_W-1:0] thresh_eff_s;
  logic [DIM_W-1:0]  width_eff_s;
  logic [DIM_W-1:0]  height_eff_s;
  logic              sol_s;
  logic              eol_s;
  logic              sof_s;
  logic              eof_s;
  logic [PROD_W-1:0] prod_r_s;
  logic [PROD_W-1:0] prod_g_s;
  logic [PROD_W-1:0] prod_b_s;

  logic              s1_valid_r;
  logic [PROD_W-1:0] s1_prod_r_r;
  logic [PROD_W-1:0] s1_prod_g_r;
  logic [PROD_W-1:0] s1_prod_b_r;
  logic [DATA_W-1:0] s1_g_r;
  logic [1:0]        s1_mode_r;
  logic [DATA_W-1:0] s1_thresh_r;
  logic [3:0]        s1_flags_r;

  logic              s2_valid_r;
  logic [SUM_W-1:0]  s2_sum_r;
  logic [DATA_W-1:0] s2_g_r;
  logic [1:0]        s2_mode_r;
  logic [DATA_W-1:0] s2_thresh_r;
  logic [3:0]        s2_flags_r;

  logic [SUM_W-1:0]  gray_full_s;
  logic [DATA_W-1:0] gray_s;
  logic [DATA_W-1:0] result_s;

  // Frame parameters in force for the incoming pixel; the first pixel of a frame uses live inputs.
  always_comb begin
    at_origin_s = (x_cnt_r == DIM_ZERO) && (y_cnt_r == DIM_ZERO);
    if (at_origin_s) begin
      mode_eff_s   = mode;
      thresh_eff_s = thresh;
      width_eff_s  = norm_dim(img_width);
      height_eff_s = norm_dim(img_height);
    end else begin
      mode_eff_s   = mode_sh_r;
      thresh_eff_s = thresh_sh_r;
      width_eff_s  = width_sh_r;
      height_eff_s = height_sh_r;
    end
  end

  // Position flags and weighted channel products of the incoming pixel.
  always_comb begin
    sol_s    = (x_cnt_r == DIM_ZERO);
    eol_s    = (x_cnt_r == (width_eff_s - DIM_ONE));
    sof_s    = sol_s && (y_cnt_r == DIM_ZERO);
    eof_s    = eol_s && (y_cnt_r == (height_eff_s - DIM_ONE));
    prod_r_s = PROD_W'(r_data) * K_R;
    prod_g_s = PROD_W'(g_data) * K_G;
    prod_b_s = PROD_W'(b_data) * K_B;
  end

  // Pixel and line counters, advanced by accepted pixels only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_r <= DIM_ZERO;
      y_cnt_r <= DIM_ZERO;
    end else if (din_valid) begin
      if (eol_s) begin
        x_cnt_r <= DIM_ZERO;
        y_cnt_r <= eof_s ? DIM_ZERO : (y_cnt_r + DIM_ONE);
      end else begin
        x_cnt_r <= x_cnt_r + DIM_ONE;
      end
    end
  end

  // Shadow copies of run-time settings, latched on the first pixel of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sh_r   <= 2'd0;
      thresh_sh_r <= PIX_ZERO;
      width_sh_r  <= DIM_ZERO;
      height_sh_r <= DIM_ZERO;
    end else if (din_valid && at_origin_s) begin
      mode_sh_r   <= mode_eff_s;
      thresh_sh_r <= thresh_eff_s;
      width_sh_r  <= width_eff_s;
      height_sh_r <= height_eff_s;
    end
  end

  // Stage 1: products, bypass channel, settings and position flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_prod_r_r <= {PROD_W{1'b0}};
      s1_prod_g_r <= {PROD_W{1'b0}};
      s1_prod_b_r <= {PROD_W{1'b0}};
      s1_g_r      <= PIX_ZERO;
      s1_mode_r   <= 2'd0;
      s1_thresh_r <= PIX_ZERO;
      s1_flags_r  <= 4'b0000;
    end else begin
      s1_valid_r  <= din_valid;
      s1_prod_r_r <= prod_r_s;
      s1_prod_g_r <= prod_g_s;
      s1_prod_b_r <= prod_b_s;
      s1_g_r      <= g_data;
      s1_mode_r   <= mode_eff_s;
      s1_thresh_r <= thresh_eff_s;
      s1_flags_r  <= din_valid ? {sol_s, eol_s, sof_s, eof_s} : 4'b0000;
    end
  end

  // Stage 2: weighted sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      s2_sum_r    <= {SUM_W{1'b0}};
      s2_g_r      <= PIX_ZERO;
      s2_mode_r   <= 2'd0;
      s2_thresh_r <= PIX_ZERO;
      s2_flags_r  <= 4'b0000;
    end else begin
      s2_valid_r  <= s1_valid_r;
      s2_sum_r    <= SUM_W'(s1_prod_r_r) + SUM_W'(s1_prod_g_r) + SUM_W'(s1_prod_b_r);
      s2_g_r      <= s1_g_r;
      s2_mode_r   <= s1_mode_r;
      s2_thresh_r <= s1_thresh_r;
      s2_flags_r  <= s1_flags_r;
    end
  end

  // Gray extraction with saturation, then per-mode pixel function.
  always_comb begin
    gray_full_s = s2_sum_r >> 8;
    if (gray_full_s > SUM_W'(PIX_MAX)) begin
      gray_s = PIX_MAX;
    end else begin
      gray_s = gray_full_s[DATA_W-1:0];
    end
    case (s2_mode_r)
      2'd0:    result_s = gray_s;
      2'd1:    result_s = (gray_s >= s2_thresh_r) ? PIX_MAX : PIX_ZERO;
      2'd2:    result_s = PIX_MAX - gray_s;
      2'd3:    result_s = s2_g_r;
      default: result_s = gray_s;
    endcase
  end

  // Stage 3: registered outputs, forced to zero in gap cycles; frame count steps with EOF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      proc_data  <= PIX_ZERO;
      dout_sol   <= 1'b0;
      dout_eol   <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      frame_cnt  <= {FCNT_W{1'b0}};
    end else begin
      dout_valid <= s2_valid_r;
      proc_data  <= s2_valid_r ? result_s : PIX_ZERO;
      dout_sol   <= s2_valid_r && s2_flags_r[3];
      dout_eol   <= s2_valid_r && s2_flags_r[2];
      dout_sof   <= s2_valid_r && s2_flags_r[1];
      dout_eof   <= s2_valid_r && s2_flags_r[0];
      if (s2_valid_r && s2_flags_r[0]) begin
        frame_cnt <= frame_cnt + FCNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_img_preproc_stream.sv
// Self-checking bench for img_preproc_stream: directed table, hand sequences and random
// traffic compared against a frame-level reference model with a 3-cycle latency queue.
module tb_img_preproc_stream;

  localparam int DW   = 8;
  localparam int DIMW = 12;
  localparam int FW   = 16;
  localparam int PMAX = 255;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            din_valid;
  logic [DW-1:0]   r_data, g_data, b_data, thresh;
  logic [DIMW-1:0] img_width, img_height;
  logic [1:0]      mode;
  logic            dout_valid, dout_sol, dout_eol, dout_sof, dout_eof;
  logic [DW-1:0]   proc_data;
  logic [FW-1:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  img_preproc_stream #(.DATA_W(DW), .DIM_W(DIMW), .COEF_R(77), .COEF_G(150),
                       .COEF_B(29), .FCNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .img_width(img_width), .img_height(img_height), .mode(mode), .thresh(thresh),
    .dout_valid(dout_valid), .proc_data(proc_data), .dout_sol(dout_sol),
    .dout_eol(dout_eol), .dout_sof(dout_sof), .dout_eof(dout_eof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int d; bit sol; bit eol; bit sof; bit eof; int fc; int tab;
  } exp_t;

  typedef struct {
    int md; int th; int r; int g; int b; int exp;
  } vec_t;

  exp_t exp_q[$];
  int mx, my, mfc, sh_mode, sh_th, sh_w, sh_h;

  function automatic int gray_of(int r, int g, int b);
    int s;
    s = (r * 77 + g * 150 + b * 29) / 256;
    if (s > PMAX) s = PMAX;
    return s;
  endfunction

  task automatic check_out(input exp_t e);
    checks++;
    if (dout_valid !== e.v || proc_data !== DW'(e.d) || dout_sol !== e.sol ||
        dout_eol !== e.eol || dout_sof !== e.sof || dout_eof !== e.eof ||
        frame_cnt !== FW'(e.fc)) begin
      errors++;
      $display("FAIL out @%0t: got v=%0b d=%0d sol=%0b eol=%0b sof=%0b eof=%0b fc=%0d, want v=%0b d=%0d sol=%0b eol=%0b sof=%0b eof=%0b fc=%0d",
               $time, dout_valid, proc_data, dout_sol, dout_eol, dout_sof, dout_eof, frame_cnt,
               e.v, e.d, e.sol, e.eol, e.sof, e.eof, e.fc);
    end
    if (e.tab >= 0) begin
      checks++;
      if (proc_data !== DW'(e.tab)) begin
        errors++;
        $display("FAIL table_pixel @%0t: got %0d want %0d", $time, proc_data, e.tab);
      end
    end
  endtask

  // One clock: check the output due now, drive a new input, predict its output.
  task automatic step(input bit v, input int r, input int g, input int b, input int md,
                      input int th, input int w, input int h, input int tab);
    exp_t e;
    int gr;
    @(negedge clk);
    if (exp_q.size() >= 3) check_out(exp_q.pop_front());
    din_valid  = v;
    r_data     = DW'(r);
    g_data     = DW'(g);
    b_data     = DW'(b);
    mode       = 2'(md);
    thresh     = DW'(th);
    img_width  = DIMW'(w);
    img_height = DIMW'(h);
    e = '{v: 1'b0, d: 0, sol: 1'b0, eol: 1'b0, sof: 1'b0, eof: 1'b0, fc: 0, tab: -1};
    if (v) begin
      if (mx == 0 && my == 0) begin
        sh_mode = md; sh_th = th;
        sh_w = (w == 0) ? 1 : w;
        sh_h = (h == 0) ? 1 : h;
      end
      gr = gray_of(r, g, b);
      case (sh_mode)
        0:       e.d = gr;
        1:       e.d = (gr >= sh_th) ? PMAX : 0;
        2:       e.d = PMAX - gr;
        default: e.d = g;
      endcase
      e.v   = 1'b1;
      e.sol = (mx == 0);
      e.eol = (mx == sh_w - 1);
      e.sof = e.sol && (my == 0);
      e.eof = e.eol && (my == sh_h - 1);
      e.tab = tab;
      if (e.eof) mfc = (mfc + 1) % 65536;
      if (e.eol) begin
        mx = 0;
        my = e.eof ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    e.fc = mfc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 1, 1, -1);
  endtask

  task automatic model_clear();
    exp_t e;
    mx = 0; my = 0; mfc = 0; sh_mode = 0; sh_th = 0; sh_w = 0; sh_h = 0;
    exp_q.delete();
    e = '{v: 1'b0, d: 0, sol: 1'b0, eol: 1'b0, sof: 1'b0, eof: 1'b0, fc: 0, tab: -1};
    for (int i = 0; i < 3; i++) exp_q.push_back(e);
  endtask

  // One-cycle reset pulse; outputs must clear while rst_n is low.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    checks++;
    if ({dout_valid, proc_data, dout_sol, dout_eol, dout_sof, dout_eof, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b d=%0d flags=%0b%0b%0b%0b fc=%0d want all 0",
               dout_valid, proc_data, dout_sol, dout_eol, dout_sof, dout_eof, frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  vec_t tab[11];

  initial begin
    int cw, ch, cmd, cth, r, g, b;
    tab[0]  = '{md: 0, th: 0,   r: 100, g: 100, b: 100, exp: 100};
    tab[1]  = '{md: 0, th: 0,   r: 255, g: 0,   b: 0,   exp: 76};
    tab[2]  = '{md: 0, th: 0,   r: 0,   g: 255, b: 0,   exp: 149};
    tab[3]  = '{md: 0, th: 0,   r: 255, g: 255, b: 255, exp: 255};
    tab[4]  = '{md: 0, th: 0,   r: 0,   g: 0,   b: 255, exp: 28};
    tab[5]  = '{md: 1, th: 128, r: 100, g: 100, b: 100, exp: 0};
    tab[6]  = '{md: 1, th: 128, r: 127, g: 127, b: 127, exp: 0};
    tab[7]  = '{md: 1, th: 128, r: 128, g: 128, b: 128, exp: 255};
    tab[8]  = '{md: 1, th: 128, r: 200, g: 200, b: 200, exp: 255};
    tab[9]  = '{md: 2, th: 0,   r: 100, g: 100, b: 100, exp: 155};
    tab[10] = '{md: 3, th: 0,   r: 200, g: 37,  b: 200, exp: 37};

    rst_n = 1'b0; din_valid = 1'b0; r_data = '0; g_data = '0; b_data = '0;
    mode = 2'd0; thresh = '0; img_width = DIMW'(1); img_height = DIMW'(1);
    repeat (2) @(negedge clk);
    checks++;
    if ({dout_valid, proc_data, dout_sol, dout_eol, dout_sof, dout_eof, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL power_on_reset: outputs not all zero (v=%0b d=%0d fc=%0d)",
               dout_valid, proc_data, frame_cnt);
    end
    rst_n = 1'b1;
    model_clear();

    // Flat gray frame 4x2
    for (int i = 0; i < 8; i++) step(1'b1, 100, 100, 100, 0, 0, 4, 2, 100);
    idle(4);

    // Directed pixel table, one-pixel frames
    for (int i = 0; i < 11; i++)
      step(1'b1, tab[i].r, tab[i].g, tab[i].b, tab[i].md, tab[i].th, 1, 1, tab[i].exp);
    idle(4);

    // Valid gaps within a 2x1 frame
    do_reset();
    step(1'b1, 10, 20, 30, 0, 0, 2, 1, -1);
    step(1'b0, 0, 0, 0, 0, 0, 2, 1, -1);
    step(1'b0, 0, 0, 0, 0, 0, 2, 1, -1);
    step(1'b1, 40, 50, 60, 0, 0, 2, 1, -1);
    idle(4);
    checks++;
    if (frame_cnt !== FW'(1)) begin
      errors++;
      $display("FAIL gap_frame_cnt: got %0d want 1", frame_cnt);
    end

    // Mid-frame settings change only applies to the next frame
    step(1'b1, 100, 100, 100, 0, 128, 4, 1, 100);
    step(1'b1, 200, 200, 200, 1, 128, 2, 1, 200);
    step(1'b1, 200, 200, 200, 1, 128, 2, 1, 200);
    step(1'b1, 200, 200, 200, 1, 128, 2, 1, 200);
    step(1'b1, 200, 200, 200, 1, 128, 2, 1, 255);
    step(1'b1, 100, 100, 100, 1, 128, 2, 1, 0);
    idle(4);

    // Reset in the middle of a frame
    step(1'b1, 90, 90, 90, 0, 0, 4, 2, 90);
    step(1'b1, 91, 91, 91, 0, 0, 4, 2, 91);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 50, 50, 50, 0, 0, 4, 2, 50);
    idle(4);

    // Random traffic against the reference model
    cw = 3; ch = 2; cmd = 0; cth = 128;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cw  = $urandom_range(0, 5);
        ch  = $urandom_range(0, 3);
        cmd = $urandom_range(0, 3);
        cth = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 7) == 0) begin
        r = 255; g = 255; b = 255;
      end else begin
        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, r, g, b, cmd, cth, cw, ch, -1);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
